// File: rtl/dispense_scheduler_if.sv
// rtl/dispense_scheduler_if.sv - request/pump bundle between switch inputs, scheduler and pump drivers
interface dispense_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int SEC_W  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*SEC_W-1:0] pour_sec;
  logic                    abort;
  logic [NUM_CH-1:0]       pump;
  logic                    busy;
  logic                    done;
  logic [CH_W-1:0]         active_ch;
  logic [SEC_W-1:0]        remain_sec;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output load, pour_sec, abort,
    input  pump, busy, done, active_ch, remain_sec, pending
  );

  modport slave (
    input  load, pour_sec, abort,
    output pump, busy, done, active_ch, remain_sec, pending
  );
endinterface

// File: rtl/dispense_scheduler.sv
// rtl/dispense_scheduler.sv - one-pump-at-a-time pour scheduler with shared seconds timer
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module dispense_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SEC_W         = 4
) (
  input logic               clk,
  input logic               RESET,
  dispense_scheduler_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W = $clog2(TICKS_PER_SEC);

  typedef enum logic [1:0] {S_IDLE, S_POUR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] load_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   active_q, active_d;
  logic [SEC_W-1:0]  remain_q, remain_d;
  logic [PS_W-1:0]   presc_q, presc_d;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pump_vec;
  logic              tick;
  logic              found;
  logic [CH_W-1:0]   sel;

  assign rise     = bus.load & ~load_q;
  assign pump_vec = (state_q == S_POUR) ? (NUM_CH'(1) << active_q) : '0;
  assign tick     = (presc_q == PS_W'(TICKS_PER_SEC - 1));

`ifdef ROUND_ROBIN_EN
  logic [CH_W-1:0] last_q, last_d;

  // Search starts just past the most recent grant, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && pending_q[(int'(last_q) + 1 + k) % NUM_CH]) begin
        found = 1'b1;
        sel   = CH_W'((int'(last_q) + 1 + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) last_q <= CH_W'(NUM_CH - 1);
    else        last_q <= last_d;
  end

  assign last_d = (state_q == S_IDLE && found) ? sel : last_q;
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        found = 1'b1;
        sel   = CH_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    remain_d  = remain_q;
    presc_d   = presc_q;
    // A re-press on the channel already pouring is dropped.
    pending_d = pending_q | (rise & ~pump_vec);
    case (state_q)
      S_IDLE: begin
        if (found) begin
          pending_d[sel] = 1'b0;
          active_d       = sel;
          remain_d       = bus.pour_sec[sel*SEC_W +: SEC_W];
          presc_d        = '0;
          state_d        = (bus.pour_sec[sel*SEC_W +: SEC_W] == '0) ? S_DONE : S_POUR;
        end
      end
      S_POUR: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          remain_d = '0;
          presc_d  = '0;
        end else if (tick) begin
          presc_d  = '0;
          remain_d = remain_q - SEC_W'(1);
          if (remain_q == SEC_W'(1)) state_d = S_DONE;
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      load_q    <= '0;
      pending_q <= '0;
      active_q  <= '0;
      remain_q  <= '0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= bus.load;
      pending_q <= pending_d;
      active_q  <= active_d;
      remain_q  <= remain_d;
      presc_q   <= presc_d;
    end
  end

  assign bus.pump       = pump_vec;
  assign bus.busy       = (state_q == S_POUR);
  assign bus.done       = (state_q == S_DONE);
  assign bus.active_ch  = active_q;
  assign bus.remain_sec = remain_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_dispense_scheduler.sv
// tb/tb_dispense_scheduler.sv - directed checks of dispense_scheduler with NUM_CH=4, TICKS_PER_SEC=4
module tb_dispense_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dispense_scheduler_if #(.NUM_CH(4), .SEC_W(4)) bus ();

  dispense_scheduler #(.NUM_CH(4), .TICKS_PER_SEC(4), .SEC_W(4)) dut (
    .clk   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.load = '0;
    bus.abort = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pour_sec = 16'h2031;
    do_reset();
    rst_n = 1'b0;
    nxt();
    chk("rst_pump", bus.pump, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_active", bus.active_ch, 0);
    chk("rst_remain", bus.remain_sec, 0);
    chk("rst_pending", bus.pending, 0);
    rst_n = 1'b1;

    // ch1 pours 3 s = 12 cycles; re-press during own pour is ignored
    bus.load = 4'b0010;
    nxt();
    chk("t1_pending", bus.pending, 4'b0010);
    chk("t1_pump_pre", bus.pump, 0);
    bus.load = 4'b0000;
    nxt();
    for (int i = 0; i < 12; i++) begin
      chk("t1_pump", bus.pump, 4'b0010);
      chk("t1_busy", bus.busy, 1);
      chk("t1_remain", bus.remain_sec, 3 - i / 4);
      chk("t1_done_low", bus.done, 0);
      if (i == 6) chk("t3_pending", bus.pending, 0);
      if (i == 5) bus.load = 4'b0010;
      if (i == 7) bus.load = 4'b0000;
      nxt();
    end
    chk("t1_done", bus.done, 1);
    chk("t1_pump_off", bus.pump, 0);
    chk("t1_remain_end", bus.remain_sec, 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      chk("t3_no_redone", bus.done, 0);
      chk("t3_no_repour", bus.pump, 0);
      chk("t1_pending_end", bus.pending, 0);
      nxt();
    end

    // simultaneous ch0 and ch2, 1 s each
    do_reset();
    bus.pour_sec = 16'h2131;
    bus.load = 4'b0101;
    nxt();
    chk("t2_pending_both", bus.pending, 4'b0101);
    bus.load = 4'b0000;
    nxt();
    for (int i = 0; i < 4; i++) begin
      chk("t2_pump_ch0", bus.pump, 4'b0001);
      chk("t2_pending_ch2", bus.pending, 4'b0100);
      nxt();
    end
    chk("t2_done0", bus.done, 1);
    nxt();
    chk("t2_idle_pump", bus.pump, 0);
    chk("t2_idle_done", bus.done, 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      chk("t2_pump_ch2", bus.pump, 4'b0100);
      chk("t2_active2", bus.active_ch, 2);
      chk("t2_remain2", bus.remain_sec, 1);
      nxt();
    end
    chk("t2_done2", bus.done, 1);
    nxt();

    // abort at cycle 5 of ch3 8-cycle pour, ch1 waiting
    bus.load = 4'b1000;
    nxt();
    chk("t4_pending3", bus.pending, 4'b1000);
    bus.load = 4'b0000;
    nxt();
    chk("t4_pump3", bus.pump, 4'b1000);
    chk("t4_remain2", bus.remain_sec, 2);
    bus.load = 4'b0010;
    nxt();
    chk("t4_pending1", bus.pending, 4'b0010);
    bus.load = 4'b0000;
    nxt();
    nxt();
    nxt();
    chk("t4_pump_c5", bus.pump, 4'b1000);
    bus.abort = 1'b1;
    nxt();
    chk("t4_abort_pump", bus.pump, 0);
    chk("t4_abort_done", bus.done, 0);
    chk("t4_abort_remain", bus.remain_sec, 0);
    chk("t4_abort_busy", bus.busy, 0);
    chk("t4_keep_pending", bus.pending, 4'b0010);
    bus.abort = 1'b0;
    nxt();
    chk("t4_grant1", bus.pump, 4'b0010);
    chk("t4_reload", bus.remain_sec, 3);
    repeat (12) nxt();
    chk("t4_done1", bus.done, 1);
    nxt();

    // zero-second pour on ch2
    bus.pour_sec = 16'h2031;
    bus.load = 4'b0100;
    nxt();
    bus.load = 4'b0000;
    nxt();
    chk("t5_done", bus.done, 1);
    chk("t5_pump", bus.pump, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_active", bus.active_ch, 2);
    nxt();
    chk("t5_done_end", bus.done, 0);
    chk("t5_pump_end", bus.pump, 0);

    // arbitration: ch0 and ch1 pending together after ch0 pour
    do_reset();
    bus.pour_sec = 16'h2131;
    bus.load = 4'b0001;
    nxt();
    bus.load = 4'b0000;
    nxt();
    chk("t6_pump0", bus.pump, 4'b0001);
    bus.load = 4'b0010;
    nxt();
    bus.load = 4'b0000;
    nxt();
    nxt();
    nxt();
    chk("t6_done0", bus.done, 1);
    bus.load = 4'b0001;
    nxt();
    chk("t6_pending01", bus.pending, 4'b0011);
    bus.load = 4'b0000;
    nxt();
`ifdef ROUND_ROBIN_EN
    chk("t6_arb", bus.pump, 4'b0010);
`else
    chk("t6_arb", bus.pump, 4'b0001);
`endif

    // reset mid-pour
    nxt();
    rst_n = 1'b0;
    nxt();
    chk("t7_pump", bus.pump, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_pending", bus.pending, 0);
    chk("t7_remain", bus.remain_sec, 0);
    chk("t7_active", bus.active_ch, 0);
    rst_n = 1'b1;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
